// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of the UART TX. It buffers host writes in a circular
// buffer and issues one byte at a time over the TX DIN/OE/RDY handshake.
module uart_tx_fifo #(
  parameter int Wdata = 8,
  parameter int Depth = 16,
  parameter int Guard = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Wdata-1:0]         DIN,
  input  logic                     WE,
  input  logic                     FLUSH,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(Depth):0]   LEVEL,
  output logic                     OVF,
  output logic [Wdata-1:0]         TX_DOUT,
  output logic                     TX_OE,
  input  logic                     TX_RDY
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned GW = $clog2(Guard + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_WAIT} state_t;

  state_t           r_state;
  logic [Wdata-1:0] r_mem [Depth];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [GW-1:0]    r_guard;

  logic             w_wr_en;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;

  // FULL is the registered flag, so a pop in the same cycle cannot admit a write.
  assign w_wr_en = WE && !FULL && !FLUSH;
  assign w_pop   = (r_state == S_ISSUE);

  always_comb begin
    w_wr_nxt = r_wr_ptr + (AW+1)'(w_wr_en);
    w_rd_nxt = r_rd_ptr + (AW+1)'(w_pop);
    if (FLUSH) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= DIN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      LEVEL    <= '0;
      FULL     <= 1'b0;
      EMPTY    <= 1'b1;
      OVF      <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      LEVEL    <= w_wr_nxt - w_rd_nxt;
      FULL     <= (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                  (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      EMPTY    <= (w_wr_nxt == w_rd_nxt);
      if (FLUSH)          OVF <= 1'b0;
      else if (WE && FULL) OVF <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_guard <= '0;
      TX_OE   <= 1'b0;
      TX_DOUT <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flush in progress must not launch a byte it is about to discard.
          if (!EMPTY && TX_RDY && !FLUSH) begin
            TX_DOUT <= r_mem[r_rd_ptr[AW-1:0]];
            TX_OE   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          TX_OE   <= 1'b0;
          r_guard <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (!TX_RDY)                        r_state <= S_WAIT;
          else if (r_guard == GW'(Guard - 1)) r_state <= S_IDLE;
          else                                r_guard <= r_guard + GW'(1);
        end
        S_WAIT: begin
          if (TX_RDY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: each task drives one scenario and checks
// its own expected values; a small TX model answers the OE/RDY handshake.
module tb_uart_tx_fifo;
  localparam int Wdata = 8;
  localparam int Depth = 16;
  localparam int Guard = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIN = '0;
  logic       WE = 1'b0;
  logic       FLUSH = 1'b0;
  logic       TX_RDY = 1'b0;
  logic       FULL, EMPTY, OVF, TX_OE;
  logic [4:0] LEVEL;
  logic [7:0] TX_DOUT;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_exp [$];

  always #5 CLK = ~CLK;

  uart_tx_fifo #(.Wdata(Wdata), .Depth(Depth), .Guard(Guard)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .WE(WE), .FLUSH(FLUSH),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF),
    .TX_DOUT(TX_DOUT), .TX_OE(TX_OE), .TX_RDY(TX_RDY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    WE = 1'b1;
    DIN = d;
    tick();
    WE = 1'b0;
    if (accept) q_exp.push_back(d);
  endtask

  // Bounded wait for the next TX_OE pulse; checks its byte against the queue.
  task automatic wait_oe(input string tag);
    int n = 0;
    logic [7:0] e;
    while (TX_OE !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (TX_OE !== 1'b1 || q_exp.size() == 0) begin
      failures++;
      $display("FAIL %s_oe_timeout oe=%b pending=%0d required oe=1", tag, TX_OE, q_exp.size());
    end else begin
      e = q_exp.pop_front();
      if (TX_DOUT !== e) begin
        failures++;
        $display("FAIL %s_dout got=%02h required=%02h", tag, TX_DOUT, e);
      end
    end
  endtask

  // TX model: RDY drops the cycle after OE and stays low for 10 cycles.
  task automatic drain(input string tag, input int budget);
    int busy_left = 0;
    int cyc = 0;
    int extra = 0;
    logic [7:0] e;
    TX_RDY = 1'b1;
    while ((q_exp.size() > 0 || busy_left > 0) && cyc < budget) begin
      tick();
      cyc++;
      if (busy_left > 0) begin
        TX_RDY = 1'b0;
        busy_left--;
      end else begin
        TX_RDY = 1'b1;
      end
      if (TX_OE === 1'b1) begin
        checks++;
        if (q_exp.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_issue dout=%02h required no issue", tag, TX_DOUT);
        end else begin
          e = q_exp.pop_front();
          if (TX_DOUT !== e) begin
            failures++;
            $display("FAIL %s_order got=%02h required=%02h", tag, TX_DOUT, e);
          end
        end
        busy_left = 10;
      end
    end
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", tag, q_exp.size());
    end
    TX_RDY = 1'b1;
    repeat (8) begin
      tick();
      if (TX_OE === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || EMPTY !== 1'b1 || LEVEL !== 5'd0) begin
      failures++;
      $display("FAIL %s_after extra=%0d empty=%b level=%0d required 0/1/0", tag, extra, EMPTY, LEVEL);
    end
  endtask

  task automatic test_reset();
    TX_RDY = 1'b0;
    #2 RST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({TX_OE, EMPTY, FULL, OVF, LEVEL, TX_DOUT} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset oe=%b empty=%b full=%b ovf=%b level=%0d dout=%02h required 0/1/0/0/0/00",
               TX_OE, EMPTY, FULL, OVF, LEVEL, TX_DOUT);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_single();
    TX_RDY = 1'b1;
    WE = 1'b1;
    DIN = 8'h41;
    tick();
    WE = 1'b0;
    checks++;
    if ({EMPTY, LEVEL, TX_OE} !== {1'b0, 5'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_n1 empty=%b level=%0d oe=%b required 0/1/0", EMPTY, LEVEL, TX_OE);
    end
    tick();
    checks++;
    if ({TX_OE, TX_DOUT, LEVEL} !== {1'b1, 8'h41, 5'd1}) begin
      failures++;
      $display("FAIL single_n2 oe=%b dout=%02h level=%0d required 1/41/1", TX_OE, TX_DOUT, LEVEL);
    end
    tick();
    checks++;
    if ({TX_OE, TX_DOUT, LEVEL, EMPTY} !== {1'b0, 8'h41, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL single_n3 oe=%b dout=%02h level=%0d empty=%b required 0/41/0/1",
               TX_OE, TX_DOUT, LEVEL, EMPTY);
    end
    repeat (8) tick();
  endtask

  task automatic test_overflow();
    TX_RDY = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    checks++;
    if ({FULL, LEVEL, OVF} !== {1'b1, 5'd16, 1'b0}) begin
      failures++;
      $display("FAIL ovf_fill full=%b level=%0d ovf=%b required 1/16/0", FULL, LEVEL, OVF);
    end
    push_byte(8'h10, 1'b0);
    checks++;
    if ({FULL, LEVEL, OVF} !== {1'b1, 5'd16, 1'b1}) begin
      failures++;
      $display("FAIL ovf_set full=%b level=%0d ovf=%b required 1/16/1", FULL, LEVEL, OVF);
    end
    drain("ovf_drain", 400);
    checks++;
    if (OVF !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b required 1", OVF);
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++;
    if (OVF !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flush ovf=%b required 0", OVF);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      TX_RDY = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + r * 16 + i), 1'b1);
      checks++;
      if ({FULL, LEVEL, OVF} !== {1'b1, 5'd16, 1'b0}) begin
        failures++;
        $display("FAIL wrap_fill round=%0d full=%b level=%0d ovf=%b required 1/16/0", r, FULL, LEVEL, OVF);
      end
      drain("wrap_drain", 400);
    end
  endtask

  task automatic test_simul();
    int n = 0;
    int cyc = 0;
    logic [7:0] e;
    TX_RDY = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b1);
    TX_RDY = 1'b1;
    while (n < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (TX_OE === 1'b1) begin
        e = q_exp.pop_front();
        checks++;
        if (TX_DOUT !== e) begin
          failures++;
          $display("FAIL simul_dout got=%02h required=%02h", TX_DOUT, e);
        end
        WE = 1'b1;
        DIN = 8'(8'h55 + n);
        q_exp.push_back(DIN);
        tick();
        WE = 1'b0;
        checks++;
        if (LEVEL !== 5'd5) begin
          failures++;
          $display("FAIL simul_level got=%0d required=5", LEVEL);
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL simul_timeout pops=%0d required=3", n);
    end
    drain("simul_drain", 400);

    TX_RDY = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i), 1'b1);
    TX_RDY = 1'b1;
    wait_oe("full_issue");
    WE = 1'b1;
    DIN = 8'hEE;
    tick();
    WE = 1'b0;
    checks++;
    if ({LEVEL, OVF, FULL} !== {5'd15, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_issue_refuse level=%0d ovf=%b full=%b required 15/1/0", LEVEL, OVF, FULL);
    end
    drain("full_issue_drain", 500);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  task automatic test_flush();
    int oes = 0;
    TX_RDY = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h70 + i), 1'b1);
    TX_RDY = 1'b1;
    wait_oe("flush_issue");
    TX_RDY = 1'b0;
    tick();
    tick();
    checks++;
    if (LEVEL !== 5'd7) begin
      failures++;
      $display("FAIL flush_pre_level got=%0d required=7", LEVEL);
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    q_exp.delete();
    checks++;
    if ({LEVEL, OVF, EMPTY, TX_DOUT} !== {5'd0, 1'b0, 1'b1, 8'h70}) begin
      failures++;
      $display("FAIL flush_clear level=%0d ovf=%b empty=%b dout=%02h required 0/0/1/70",
               LEVEL, OVF, EMPTY, TX_DOUT);
    end
    TX_RDY = 1'b1;
    repeat (20) begin
      tick();
      if (TX_OE === 1'b1) oes++;
    end
    checks++;
    if (oes != 0) begin
      failures++;
      $display("FAIL flush_no_issue oes=%0d required=0", oes);
    end
    FLUSH = 1'b1;
    WE = 1'b1;
    DIN = 8'h99;
    tick();
    FLUSH = 1'b0;
    WE = 1'b0;
    tick();
    checks++;
    if ({LEVEL, EMPTY, OVF, TX_OE} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_we level=%0d empty=%b ovf=%b oe=%b required 0/1/0/0", LEVEL, EMPTY, OVF, TX_OE);
    end
  endtask

  task automatic test_guard_and_reset();
    int n = 0;
    TX_RDY = 1'b0;
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b1);
    TX_RDY = 1'b1;
    wait_oe("guard_first");
    tick();
    n = 1;
    while (TX_OE !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 6 || TX_DOUT !== 8'hA2) begin
      failures++;
      $display("FAIL guard_gap cycles=%0d dout=%02h required 6/A2", n, TX_DOUT);
    end
    q_exp.delete();
    repeat (8) tick();

    TX_RDY = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'(8'hB0 + i), i < 16);
    TX_RDY = 1'b1;
    wait_oe("rst_issue");
    TX_RDY = 1'b0;
    tick();
    tick();
    checks++;
    if ({OVF, LEVEL, TX_DOUT} !== {1'b1, 5'd15, 8'hB0}) begin
      failures++;
      $display("FAIL rst_pre ovf=%b level=%0d dout=%02h required 1/15/B0", OVF, LEVEL, TX_DOUT);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({TX_OE, EMPTY, FULL, OVF, LEVEL, TX_DOUT} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00}) begin
      failures++;
      $display("FAIL rst_async oe=%b empty=%b full=%b ovf=%b level=%0d dout=%02h required 0/1/0/0/0/00",
               TX_OE, EMPTY, FULL, OVF, LEVEL, TX_DOUT);
    end
    #2 RST = 1'b1;
    q_exp.delete();
    TX_RDY = 1'b1;
    repeat (4) tick();
    checks++;
    if ({TX_OE, EMPTY, LEVEL} !== {1'b0, 1'b1, 5'd0}) begin
      failures++;
      $display("FAIL rst_after oe=%b empty=%b level=%0d required 0/1/0", TX_OE, EMPTY, LEVEL);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_wrap();
    test_simul();
    test_flush();
    test_guard_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
